// File: rtl/p405s_itlb_shadowlookup_if.sv
// Request/response bundle between the ITLB fetch front-end and the shadow-TLB lookup.
// Vectors are big-endian (bit 0 = MSB), matching the PowerPC EPN numbering.
interface p405s_itlb_shadowlookup_if #(
   parameter int EPN_W  = 22,
   parameter int SIZE_W = 7,
   parameter int IDX_W  = 2
);
   logic              lookup_valid;
   logic [0:EPN_W-1]  is_ea;
   logic              msr_ir_l2;
   logic              is_abort_neg;
   logic              write_shadow;
   logic [0:EPN_W-1]  wr_epn;
   logic [0:SIZE_W-1] wr_size;
   logic              invalidate_all;
   logic              rsp_valid;
   logic              hit;
   logic              miss;
   logic [IDX_W-1:0]  hit_idx;
   logic              multi_hit;
   logic [IDX_W-1:0]  victim_idx;

   modport master (
      output lookup_valid, is_ea, msr_ir_l2, is_abort_neg,
             write_shadow, wr_epn, wr_size, invalidate_all,
      input  rsp_valid, hit, miss, hit_idx, multi_hit, victim_idx
   );

   modport slave (
      input  lookup_valid, is_ea, msr_ir_l2, is_abort_neg,
             write_shadow, wr_epn, wr_size, invalidate_all,
      output rsp_valid, hit, miss, hit_idx, multi_hit, victim_idx
   );
endinterface

// File: rtl/p405s_itlb_shadowlookup.sv
// N-entry instruction shadow-TLB: masked EPN compare, registered hit/miss, round-robin refill.
// Lookups always see pre-edge contents; writes and invalidates land at the same edge.
module p405s_itlb_shadowlookup #(
   parameter int ENTRIES = 4,
   parameter int EPN_W   = 22,
   parameter int SIZE_W  = 7
) (
   input  logic cb,
   input  logic reset_core,
   p405s_itlb_shadowlookup_if.slave bus
);
   localparam int IDX_W = $clog2(ENTRIES);
   localparam int BASE  = EPN_W - 2*SIZE_W;

   logic [0:EPN_W-1]  epn_q  [ENTRIES];
   logic [0:SIZE_W-1] size_q [ENTRIES];
   logic [ENTRIES-1:0] valid_q;
   logic [IDX_W-1:0]   victim_q;

   logic [0:EPN_W-1]   care_mask [ENTRIES];
   logic [ENTRIES-1:0] match;
   logic [IDX_W-1:0]   enc_idx;
   logic               any_match;
   logic               many_match;
   logic               found;
   logic               accept;
   logic               wr_en;
   logic               miss_nxt;

   logic               rsp_valid_q;
   logic               hit_q;
   logic               miss_q;
   logic [IDX_W-1:0]   hit_idx_q;
   logic               multi_hit_q;

   assign accept = bus.lookup_valid & bus.is_abort_neg;
   assign wr_en  = bus.write_shadow & bus.is_abort_neg & ~bus.invalidate_all;

   // Each size bit j drops the EPN pair (BASE+2j, BASE+2j+1) from the compare.
   always_comb begin
      for (int e = 0; e < ENTRIES; e++) begin
         care_mask[e] = '1;
         for (int j = 0; j < SIZE_W; j++) begin
            if (size_q[e][j]) begin
               care_mask[e][BASE+2*j]   = 1'b0;
               care_mask[e][BASE+2*j+1] = 1'b0;
            end
         end
         match[e] = valid_q[e] & (((epn_q[e] ^ bus.is_ea) & care_mask[e]) == '0);
      end
   end

   always_comb begin
      enc_idx    = '0;
      found      = 1'b0;
      many_match = 1'b0;
      for (int e = 0; e < ENTRIES; e++) begin
         if (match[e]) begin
            if (found) many_match = 1'b1;
            else       enc_idx    = IDX_W'(e);
            found = 1'b1;
         end
      end
      any_match = found;
      miss_nxt  = bus.msr_ir_l2 & ~any_match;
   end

   always_ff @(posedge cb or posedge reset_core) begin
      if (reset_core) begin
         rsp_valid_q <= 1'b0;
         hit_q       <= 1'b0;
         miss_q      <= 1'b0;
         hit_idx_q   <= '0;
         multi_hit_q <= 1'b0;
      end else begin
         rsp_valid_q <= accept;
         if (accept) begin
            miss_q      <= miss_nxt;
            hit_q       <= ~miss_nxt;
            hit_idx_q   <= enc_idx;
            multi_hit_q <= bus.msr_ir_l2 & many_match;
         end
      end
   end

   always_ff @(posedge cb or posedge reset_core) begin
      if (reset_core) begin
         valid_q  <= '0;
         victim_q <= '0;
      end else if (bus.invalidate_all) begin
         valid_q  <= '0;
         victim_q <= '0;
      end else if (wr_en) begin
         valid_q[victim_q] <= 1'b1;
         victim_q          <= victim_q + 1'b1;
      end
   end

   // Tag storage carries no reset; valid_q alone qualifies it.
   always_ff @(posedge cb) begin
      if (wr_en) begin
         epn_q[victim_q]  <= bus.wr_epn;
         size_q[victim_q] <= bus.wr_size;
      end
   end

   assign bus.rsp_valid  = rsp_valid_q;
   assign bus.hit        = hit_q;
   assign bus.miss       = miss_q;
   assign bus.hit_idx    = hit_idx_q;
   assign bus.multi_hit  = multi_hit_q;
   assign bus.victim_idx = victim_q;
endmodule

// File: tb/tb_p405s_itlb_shadowlookup.sv
// Self-checking bench for the shadow-TLB lookup: directed scenarios plus a randomized run
// against a table-based reference model.
module tb_p405s_itlb_shadowlookup;
   localparam int ENTRIES = 4;
   localparam int EPN_W   = 22;
   localparam int SIZE_W  = 7;
   localparam int IDX_W   = 2;

   logic cb = 1'b0;
   logic reset_core;
   always #5 cb = ~cb;

   p405s_itlb_shadowlookup_if #(.EPN_W(EPN_W), .SIZE_W(SIZE_W), .IDX_W(IDX_W)) bus ();

   p405s_itlb_shadowlookup #(.ENTRIES(ENTRIES), .EPN_W(EPN_W), .SIZE_W(SIZE_W)) dut (
      .cb         (cb),
      .reset_core (reset_core),
      .bus        (bus.slave)
   );

   int tests_run    = 0;
   int tests_failed = 0;

   // Reference model: plain table of entries plus a FIFO-style victim pointer.
   bit          m_valid [ENTRIES];
   logic [21:0] m_epn   [ENTRIES];
   logic [6:0]  m_size  [ENTRIES];
   int          m_victim;
   bit          m_rsp, m_hit, m_miss, m_multi;
   int          m_idx;

   // Integer size bit k hides value bits 2k and 2k+1 of the page number.
   function automatic logic [21:0] ignore_bits(input logic [6:0] s);
      logic [21:0] m;
      m = '0;
      for (int k = 0; k < 7; k++)
         if (s[k]) m = m | (22'h3 << (2*k));
      return m;
   endfunction

   function automatic logic [7:0] dut_vec();
      return {bus.rsp_valid, bus.hit, bus.miss, bus.hit_idx, bus.multi_hit, bus.victim_idx};
   endfunction

   function automatic logic [7:0] model_vec();
      return {m_rsp, m_hit, m_miss, 2'(m_idx), m_multi, 2'(m_victim)};
   endfunction

   task automatic model_reset();
      for (int e = 0; e < ENTRIES; e++) m_valid[e] = 1'b0;
      m_victim = 0;
      m_rsp = 0; m_hit = 0; m_miss = 0; m_multi = 0; m_idx = 0;
   endtask

   // Drive one cycle of inputs, advance the model at the edge, return 1ns after it.
   task automatic drive(input bit lv, input logic [21:0] ea, input bit ir, input bit an,
                        input bit ws, input logic [21:0] wepn, input logic [6:0] wsz,
                        input bit inv);
      int first, cnt;
      bus.lookup_valid   = lv;
      bus.is_ea          = ea;
      bus.msr_ir_l2      = ir;
      bus.is_abort_neg   = an;
      bus.write_shadow   = ws;
      bus.wr_epn         = wepn;
      bus.wr_size        = wsz;
      bus.invalidate_all = inv;
      @(posedge cb);
      if (lv && an) begin
         first = -1; cnt = 0;
         for (int e = 0; e < ENTRIES; e++) begin
            if (m_valid[e] && (((ea ^ m_epn[e]) & ~ignore_bits(m_size[e])) == 22'd0)) begin
               if (first < 0) first = e;
               cnt++;
            end
         end
         m_rsp   = 1;
         m_miss  = ir && (cnt == 0);
         m_hit   = !m_miss;
         m_idx   = (first < 0) ? 0 : first;
         m_multi = ir && (cnt > 1);
      end else begin
         m_rsp = 0;
      end
      if (inv) begin
         for (int e = 0; e < ENTRIES; e++) m_valid[e] = 1'b0;
         m_victim = 0;
      end else if (ws && an) begin
         m_valid[m_victim] = 1'b1;
         m_epn[m_victim]   = wepn;
         m_size[m_victim]  = wsz;
         m_victim = (m_victim + 1) % ENTRIES;
      end
      #1;
   endtask

   task automatic lookup(input logic [21:0] ea);
      drive(1, ea, 1, 1, 0, 22'd0, 7'd0, 0);
   endtask

   task automatic write(input logic [21:0] epn, input logic [6:0] sz);
      drive(0, 22'd0, 1, 1, 1, epn, sz, 0);
   endtask

   task automatic test_reset();
      reset_core = 1'b1;
      drive(0, 22'd0, 1, 1, 0, 22'd0, 7'd0, 0);
      model_reset();
      tests_run++;
      if (dut_vec() !== 8'b0) begin
         tests_failed++;
         $display("FAIL reset_state got %b expected %b", dut_vec(), 8'b0);
      end
      #3 reset_core = 1'b0;
      drive(0, 22'd0, 1, 1, 0, 22'd0, 7'd0, 0);
      tests_run++;
      if (dut_vec() !== 8'b0) begin
         tests_failed++;
         $display("FAIL reset_release got %b expected %b", dut_vec(), 8'b0);
      end
   endtask

   task automatic test_first_miss();
      lookup(22'h0ABCDE);
      tests_run++;
      if (dut_vec() !== 8'b1_0_1_00_0_00) begin
         tests_failed++;
         $display("FAIL first_miss got %b expected %b", dut_vec(), 8'b1_0_1_00_0_00);
      end
   endtask

   task automatic test_write_hit();
      write(22'h0ABCDE, 7'd0);
      tests_run++;
      if (dut_vec() !== 8'b0_0_1_00_0_01) begin
         tests_failed++;
         $display("FAIL write_hold got %b expected %b", dut_vec(), 8'b0_0_1_00_0_01);
      end
      lookup(22'h0ABCDE);
      tests_run++;
      if (dut_vec() !== 8'b1_1_0_00_0_01) begin
         tests_failed++;
         $display("FAIL exact_hit got %b expected %b", dut_vec(), 8'b1_1_0_00_0_01);
      end
      lookup(22'h0ABCDF);
      tests_run++;
      if (dut_vec() !== 8'b1_0_1_00_0_01) begin
         tests_failed++;
         $display("FAIL lsb_miss got %b expected %b", dut_vec(), 8'b1_0_1_00_0_01);
      end
   endtask

   task automatic test_size_mask();
      write(22'h012300, 7'b0000011);
      lookup(22'h01230F);
      tests_run++;
      if (dut_vec() !== 8'b1_1_0_01_0_10) begin
         tests_failed++;
         $display("FAIL masked_hit got %b expected %b", dut_vec(), 8'b1_1_0_01_0_10);
      end
      lookup(22'h01231F);
      tests_run++;
      if (dut_vec() !== 8'b1_0_1_00_0_10) begin
         tests_failed++;
         $display("FAIL unmasked_miss got %b expected %b", dut_vec(), 8'b1_0_1_00_0_10);
      end
   endtask

   task automatic test_multi_hit();
      drive(0, 22'd0, 1, 1, 0, 22'd0, 7'd0, 1);
      write(22'h155555, 7'd0);
      write(22'h2AAAAA, 7'd0);
      write(22'h155555, 7'd0);
      tests_run++;
      if (bus.victim_idx !== 2'd3) begin
         tests_failed++;
         $display("FAIL victim_before_wrap got %0d expected 3", bus.victim_idx);
      end
      write(22'h300000, 7'd0);
      tests_run++;
      if (bus.victim_idx !== 2'd0) begin
         tests_failed++;
         $display("FAIL victim_wrap got %0d expected 0", bus.victim_idx);
      end
      lookup(22'h155555);
      tests_run++;
      if (dut_vec() !== 8'b1_1_0_00_1_00) begin
         tests_failed++;
         $display("FAIL multi_hit got %b expected %b", dut_vec(), 8'b1_1_0_00_1_00);
      end
      lookup(22'h300000);
      tests_run++;
      if (dut_vec() !== 8'b1_1_0_11_0_00) begin
         tests_failed++;
         $display("FAIL entry3_hit got %b expected %b", dut_vec(), 8'b1_1_0_11_0_00);
      end
   endtask

   task automatic test_write_lookup_same_cycle();
      drive(0, 22'd0, 1, 1, 0, 22'd0, 7'd0, 1);
      drive(1, 22'h1F0F0F, 1, 1, 1, 22'h1F0F0F, 7'd0, 0);
      tests_run++;
      if (dut_vec() !== 8'b1_0_1_00_0_01) begin
         tests_failed++;
         $display("FAIL pre_write_view got %b expected %b", dut_vec(), 8'b1_0_1_00_0_01);
      end
      lookup(22'h1F0F0F);
      tests_run++;
      if (dut_vec() !== 8'b1_1_0_00_0_01) begin
         tests_failed++;
         $display("FAIL post_write_hit got %b expected %b", dut_vec(), 8'b1_1_0_00_0_01);
      end
   endtask

   task automatic test_invalidate_priority();
      write(22'h222222, 7'd0);
      drive(1, 22'h1F0F0F, 1, 1, 1, 22'h333333, 7'd0, 1);
      tests_run++;
      if (dut_vec() !== 8'b1_1_0_00_0_00) begin
         tests_failed++;
         $display("FAIL inv_same_cycle_lookup got %b expected %b", dut_vec(), 8'b1_1_0_00_0_00);
      end
      lookup(22'h333333);
      tests_run++;
      if (dut_vec() !== 8'b1_0_1_00_0_00) begin
         tests_failed++;
         $display("FAIL dropped_write got %b expected %b", dut_vec(), 8'b1_0_1_00_0_00);
      end
      lookup(22'h222222);
      tests_run++;
      if (dut_vec() !== 8'b1_0_1_00_0_00) begin
         tests_failed++;
         $display("FAIL invalidated_entry got %b expected %b", dut_vec(), 8'b1_0_1_00_0_00);
      end
   endtask

   task automatic test_abort();
      write(22'h0C0C0C, 7'd0);
      lookup(22'h0C0C0C);
      drive(1, 22'h3FFFFF, 1, 0, 1, 22'h3FFFFF, 7'd0, 0);
      tests_run++;
      if (dut_vec() !== 8'b0_1_0_00_0_01) begin
         tests_failed++;
         $display("FAIL abort_hold got %b expected %b", dut_vec(), 8'b0_1_0_00_0_01);
      end
      lookup(22'h3FFFFF);
      tests_run++;
      if (dut_vec() !== 8'b1_0_1_00_0_01) begin
         tests_failed++;
         $display("FAIL abort_write_dropped got %b expected %b", dut_vec(), 8'b1_0_1_00_0_01);
      end
   endtask

   task automatic test_real_mode();
      drive(0, 22'd0, 1, 1, 0, 22'd0, 7'd0, 1);
      drive(1, 22'h123456, 0, 1, 0, 22'd0, 7'd0, 0);
      tests_run++;
      if (dut_vec() !== 8'b1_1_0_00_0_00) begin
         tests_failed++;
         $display("FAIL real_mode got %b expected %b", dut_vec(), 8'b1_1_0_00_0_00);
      end
      drive(0, 22'd0, 1, 1, 0, 22'd0, 7'd0, 0);
      tests_run++;
      if (dut_vec() !== 8'b0_1_0_00_0_00) begin
         tests_failed++;
         $display("FAIL idle_hold got %b expected %b", dut_vec(), 8'b0_1_0_00_0_00);
      end
   endtask

   task automatic test_random();
      logic [21:0] pool [6];
      logic [21:0] ea, wepn;
      logic [6:0]  wsz;
      bit lv, ir, an, ws, inv;
      for (int p = 0; p < 6; p++) pool[p] = 22'($urandom);
      for (int i = 0; i < 400; i++) begin
         ea = pool[$urandom_range(0, 5)];
         if ($urandom_range(0, 2) == 0) ea = ea ^ 22'($urandom_range(0, 15));
         if ($urandom_range(0, 9) == 0) ea = 22'($urandom);
         wepn = pool[$urandom_range(0, 5)];
         wsz  = ($urandom_range(0, 2) == 0) ? 7'($urandom_range(0, 3)) : 7'd0;
         lv   = ($urandom_range(0, 9) < 7);
         ir   = ($urandom_range(0, 9) < 8);
         an   = ($urandom_range(0, 9) < 9);
         ws   = ($urandom_range(0, 9) < 3);
         inv  = ($urandom_range(0, 39) == 0);
         drive(lv, ea, ir, an, ws, wepn, wsz, inv);
         tests_run++;
         if (dut_vec() !== model_vec()) begin
            tests_failed++;
            $display("FAIL random[%0d] got %b expected %b", i, dut_vec(), model_vec());
         end
      end
   endtask

   task automatic test_reset_mid_lookup();
      write(22'h0F0F0F, 7'd0);
      lookup(22'h0F0F0F);
      bus.lookup_valid = 1'b1;
      #2 reset_core = 1'b1;
      #1;
      model_reset();
      tests_run++;
      if (dut_vec() !== 8'b0) begin
         tests_failed++;
         $display("FAIL async_reset got %b expected %b", dut_vec(), 8'b0);
      end
      @(posedge cb);
      #2 reset_core = 1'b0;
      drive(0, 22'h0F0F0F, 1, 1, 0, 22'd0, 7'd0, 0);
      tests_run++;
      if (dut_vec() !== 8'b0) begin
         tests_failed++;
         $display("FAIL no_rsp_after_reset got %b expected %b", dut_vec(), 8'b0);
      end
      lookup(22'h0F0F0F);
      tests_run++;
      if (dut_vec() !== 8'b1_0_1_00_0_00) begin
         tests_failed++;
         $display("FAIL entries_cleared got %b expected %b", dut_vec(), 8'b1_0_1_00_0_00);
      end
   endtask

   initial begin
      bus.lookup_valid   = 1'b0;
      bus.is_ea          = '0;
      bus.msr_ir_l2      = 1'b1;
      bus.is_abort_neg   = 1'b1;
      bus.write_shadow   = 1'b0;
      bus.wr_epn         = '0;
      bus.wr_size        = '0;
      bus.invalidate_all = 1'b0;
      reset_core         = 1'b1;
      model_reset();
      test_reset();
      test_first_miss();
      test_write_hit();
      test_size_mask();
      test_multi_hit();
      test_write_lookup_same_cycle();
      test_invalidate_priority();
      test_abort();
      test_real_mode();
      test_random();
      test_reset_mid_lookup();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule

// File: doc/p405s_itlb_shadowlookup.md
Name: p405s_itlb_shadowLookup

Overview:
- Parametrised N-entry instruction shadow-TLB lookup for the PR_mmu ITLB. Generalises the single-entry registered comparator to ENTRIES entries with configurable EPN width and page-size masking.
- Adds an entry write port, round-robin victim selection, invalidate-all, priority hit-index encoding and multi-hit detection.
- Sits between instruction-side EA generation and the UTLB refill path. The registered Hit/Miss gates fetch.

Parameters:
- ENTRIES, 4, number of shadow entries (power of 2, 2..16); IDX_W = clog2(ENTRIES), derived localparam.
- EPN_W, 22, effective page number width (bit 0 = MSB).
- SIZE_W, 7, page-size mask bits; each masks 2 EPN LSB-side bits; 2*SIZE_W <= EPN_W.

Ports:
- CB  in  1  core clock, all state on posedge.
- resetCore  in  1  asynchronous active-high reset.
- lookupValid  in  1  compare request this cycle.
- isEA  in  [0:EPN_W-1]  fetch EA page bits to compare.
- msrIrL2  in  1  instruction relocate enabled (1 = translate).
- isAbort_NEG  in  1  0 = abort: kills lookup and write this cycle.
- writeShadow  in  1  load entry at victimIdx.
- wrEPN  in  [0:EPN_W-1]  EPN to load.
- wrSize  in  [0:SIZE_W-1]  size mask to load.
- invalidateAll  in  1  clear all entries.
- rspValid  out  1  Hit/Miss/hitIdx/multiHit valid.
- Hit  out  1  translation hit or real mode.
- Miss  out  1  relocate on and no entry matched.
- hitIdx  out  IDX_W  lowest matching entry index.
- multiHit  out  1  more than one entry matched.
- victimIdx  out  IDX_W  next entry to be written.

Behaviour:
- Reset (async, immediate): all entry valid bits 0; victimIdx 0; rspValid, Hit, Miss, multiHit 0; hitIdx 0. EPN/size storage is not reset.
- Match for entry e: valid[e] & all unmasked bits equal.
  - Size[j]=1 masks EPN bits (EPN_W-2*SIZE_W+2j) and the next bit.
  - Defaults: Size[0] masks EPN[8:9]; Size[6] masks EPN[20:21]; EPN[0:7] are always compared.
- Lookup latency 1: a request sampled at posedge k updates the outputs after posedge k. No backpressure.
- Accepted lookup (lookupValid & isAbort_NEG) updates the result registers:
  - rspValid = 1.
  - Miss = msrIrL2 & ~anyMatch; Hit = ~Miss.
  - hitIdx = lowest matching index, or 0 if none.
  - multiHit = msrIrL2 & (popcount(match) > 1).
- Real mode (msrIrL2=0): Hit=1, Miss=0, multiHit=0. hitIdx is still the encoded match.
- lookupValid=0: rspValid=0 next cycle; Hit/Miss/hitIdx/multiHit hold their previous values.
- Abort (isAbort_NEG=0 with lookupValid=1): rspValid=0 next cycle, result registers hold. Any writeShadow in the same cycle is suppressed.
- Write (writeShadow & isAbort_NEG & ~invalidateAll):
  - entry[victimIdx] ← {wrEPN, wrSize, valid=1}.
  - victimIdx ← victimIdx+1 mod ENTRIES (wraps ENTRIES-1 → 0).
- Write and lookup in the same cycle: the lookup compares against pre-write contents; the new entry is matchable from the next cycle.
- invalidateAll: all valids ← 0 and victimIdx ← 0 at the next edge.
  - Has priority over a same-cycle write, which is dropped.
  - A same-cycle lookup sees the old contents.
- Reset asserted mid-lookup: outputs clear immediately. The first rspValid after reset release needs a fresh lookupValid.
- Outputs are registered only, with no combinational input-to-output path, except that victimIdx is a register output.

Test Plan:
- Reset, then lookup isEA=22'h0ABCDE with msrIrL2=1 → next cycle rspValid=1, Miss=1, Hit=0, victimIdx=0.
- Write wrEPN=22'h0ABCDE, wrSize=0; lookup same EA next cycle → Hit=1, Miss=0, hitIdx=0, victimIdx=1. Lookup EA 22'h0ABCDF → Miss=1.
- Write entry1 with wrEPN=22'h012300, wrSize=7'b0000011 → lookup 22'h01230F hits, hitIdx=1. Lookup 22'h01231F (EPN[17] differs, unmasked) misses.
- Load entries 0 and 2 with the same EPN (the intervening entry-1 write uses a different EPN; four writes total) → lookup gives hitIdx=0, multiHit=1. victimIdx wraps 3→0 after the 4th write.
- Same-cycle write of EA X and lookup of X → Miss=1. The following lookup of X → Hit=1.
- invalidateAll + writeShadow same cycle → all lookups Miss, victimIdx=0. isAbort_NEG=0 with lookupValid=1 → rspValid=0 and Hit/Miss hold. msrIrL2=0 → Hit=1, Miss=0 with no entries valid.
